// File: rtl/rv32_alu_operand_stage.sv
// RV32 operand-select stage: resolves EX/WB forwarding, muxes ALU operands,
// and holds the result in a one-entry valid/ready pipeline register.
module rv32_alu_operand_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      in_alu_opsel,
   input  logic [4:0]      in_rs1_addr,
   input  logic [4:0]      in_rs2_addr,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_imm,
   input  logic [1:0]      in_a_sel,
   input  logic            in_b_sel,
   input  logic [4:0]      in_rd,
   input  logic            fwd_ex_en,
   input  logic [4:0]      fwd_ex_rd,
   input  logic [XLEN-1:0] fwd_ex_data,
   input  logic            fwd_wb_en,
   input  logic [4:0]      fwd_wb_rd,
   input  logic [XLEN-1:0] fwd_wb_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      alu_opsel,
   output logic [XLEN-1:0] opA,
   output logic [XLEN-1:0] opB,
   output logic [4:0]      out_rd
);

   logic            capture;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;
   logic [XLEN-1:0] opa_next;
   logic [XLEN-1:0] opb_next;

   assign in_ready = !out_valid || out_ready;
   assign capture  = in_valid && in_ready && !flush;

   // EX beats WB; x0 is hardwired so it never takes a forwarded value.
   always_comb begin
      rs1_fwd = in_rs1_data;
      if (fwd_ex_en && (fwd_ex_rd == in_rs1_addr) && (in_rs1_addr != 5'd0))
         rs1_fwd = fwd_ex_data;
      else if (fwd_wb_en && (fwd_wb_rd == in_rs1_addr) && (in_rs1_addr != 5'd0))
         rs1_fwd = fwd_wb_data;

      rs2_fwd = in_rs2_data;
      if (fwd_ex_en && (fwd_ex_rd == in_rs2_addr) && (in_rs2_addr != 5'd0))
         rs2_fwd = fwd_ex_data;
      else if (fwd_wb_en && (fwd_wb_rd == in_rs2_addr) && (in_rs2_addr != 5'd0))
         rs2_fwd = fwd_wb_data;
   end

   always_comb begin
      opa_next = '0;
      case (in_a_sel)
         2'd0:    opa_next = rs1_fwd;
         2'd1:    opa_next = in_pc;
         default: opa_next = '0;
      endcase
      opb_next = in_b_sel ? in_imm : rs2_fwd;
   end

   // Data fields only move on capture, so a stalled entry stays frozen.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         alu_opsel <= '0;
         opA       <= '0;
         opB       <= '0;
         out_rd    <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         alu_opsel <= in_alu_opsel;
         opA       <= opa_next;
         opB       <= opb_next;
         out_rd    <= in_rd;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32_alu_operand_stage.sv
// Directed self-checking bench for rv32_alu_operand_stage with hand-computed
// expectations for capture, forwarding, stall, flush and reset behaviour.
module tb_rv32_alu_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_alu_opsel;
   logic [4:0]  in_rs1_addr, in_rs2_addr;
   logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm;
   logic [1:0]  in_a_sel;
   logic        in_b_sel;
   logic [4:0]  in_rd;
   logic        fwd_ex_en, fwd_wb_en;
   logic [4:0]  fwd_ex_rd, fwd_wb_rd;
   logic [31:0] fwd_ex_data, fwd_wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_opsel;
   logic [31:0] opA, opB;
   logic [4:0]  out_rd;

   int total = 0;
   int bad   = 0;

   rv32_alu_operand_stage #(.XLEN(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_opsel(in_alu_opsel),
      .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
      .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .in_pc(in_pc), .in_imm(in_imm),
      .in_a_sel(in_a_sel), .in_b_sel(in_b_sel), .in_rd(in_rd),
      .fwd_ex_en(fwd_ex_en), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_en(fwd_wb_en), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_opsel(alu_opsel), .opA(opA), .opB(opB), .out_rd(out_rd)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] opsel,
                                input logic [1:0] asel, input logic bsel,
                                input logic [4:0] r1a, input logic [31:0] r1d,
                                input logic [4:0] r2a, input logic [31:0] r2d,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [4:0] rd);
      in_valid     = v;
      in_alu_opsel = opsel;
      in_a_sel     = asel;
      in_b_sel     = bsel;
      in_rs1_addr  = r1a;
      in_rs1_data  = r1d;
      in_rs2_addr  = r2a;
      in_rs2_data  = r2d;
      in_pc        = pc;
      in_imm       = imm;
      in_rd        = rd;
      #1;
   endtask

   task automatic setForward(input logic exen, input logic [4:0] exrd, input logic [31:0] exd,
                             input logic wben, input logic [4:0] wbrd, input logic [31:0] wbd);
      fwd_ex_en   = exen;
      fwd_ex_rd   = exrd;
      fwd_ex_data = exd;
      fwd_wb_en   = wben;
      fwd_wb_rd   = wbrd;
      fwd_wb_data = wbd;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag, input logic v, input logic [3:0] opsel,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      checkOutput({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
      checkOutput({tag, ".opsel"}, {28'd0, alu_opsel}, {28'd0, opsel});
      checkOutput({tag, ".opA"}, opA, a);
      checkOutput({tag, ".opB"}, opB, b);
      checkOutput({tag, ".rd"}, {27'd0, out_rd}, {27'd0, rd});
   endtask

   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;
      setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      applyStimulus(1'b1, 4'd9, 2'd0, 1'b0, 5'd1, 32'h99, 5'd2, 32'h98, 32'h0, 32'h0, 5'd3);
      tick();
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
      checkAll("reset", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
      checkOutput("reset.in_ready", {31'd0, in_ready}, 32'd1);

      // Basic capture: rs1=5, rs2=7, one-cycle latency, then drain.
      applyStimulus(1'b1, 4'd0, 2'd0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 32'h0, 5'd4);
      tick();
      checkAll("basic", 1'b1, 4'd0, 32'd5, 32'd7, 5'd4);
      applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      checkAll("drain", 1'b0, 4'd0, 32'd5, 32'd7, 5'd4);

      // Back-to-back stream covering AUIPC, forwarding priority, x0 and a_sel 2/3.
      applyStimulus(1'b1, 4'd15, 2'd1, 1'b1, 5'd1, 32'h5, 5'd2, 32'h7, 32'h100, 32'h2000, 5'd5);
      tick();
      checkAll("auipc", 1'b1, 4'd15, 32'h100, 32'h2000, 5'd5);
      setForward(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
      applyStimulus(1'b1, 4'd1, 2'd0, 1'b0, 5'd3, 32'h11, 5'd9, 32'h22, 32'h0, 32'h0, 5'd6);
      tick();
      checkAll("fwd_ex_prio", 1'b1, 4'd1, 32'hAA, 32'h22, 5'd6);
      setForward(1'b1, 5'd3, 32'hAA, 1'b1, 5'd7, 32'hBB);
      applyStimulus(1'b1, 4'd2, 2'd0, 1'b0, 5'd3, 32'h11, 5'd7, 32'h22, 32'h0, 32'h0, 5'd7);
      tick();
      checkAll("fwd_wb_rs2", 1'b1, 4'd2, 32'hAA, 32'hBB, 5'd7);
      setForward(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
      applyStimulus(1'b1, 4'd3, 2'd0, 1'b0, 5'd0, 32'h33, 5'd0, 32'h34, 32'h0, 32'h0, 5'd8);
      tick();
      checkAll("x0_nofwd", 1'b1, 4'd3, 32'h33, 32'h34, 5'd8);
      setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      applyStimulus(1'b1, 4'd4, 2'd2, 1'b1, 5'd1, 32'h44, 5'd2, 32'h45, 32'h500, 32'h600, 5'd9);
      tick();
      checkAll("asel_zero", 1'b1, 4'd4, 32'h0, 32'h600, 5'd9);
      applyStimulus(1'b1, 4'd5, 2'd3, 1'b0, 5'd1, 32'h44, 5'd2, 32'h45, 32'h500, 32'h600, 5'd10);
      tick();
      checkAll("asel_rsvd", 1'b1, 4'd5, 32'h0, 32'h45, 5'd10);
      applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      checkOutput("stream_drain.valid", {31'd0, out_valid}, 32'd0);

      // Stall: A is held for 3 cycles while B waits and a new forward appears.
      out_ready = 1'b0;
      applyStimulus(1'b1, 4'd1, 2'd0, 1'b0, 5'd1, 32'h1000, 5'd2, 32'h2000, 32'h0, 32'h0, 5'd10);
      tick();
      checkAll("stallA", 1'b1, 4'd1, 32'h1000, 32'h2000, 5'd10);
      applyStimulus(1'b1, 4'd2, 2'd0, 1'b0, 5'd2, 32'h3000, 5'd3, 32'h4000, 32'h0, 32'h0, 5'd11);
      setForward(1'b1, 5'd1, 32'hDEAD, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checkOutput("stall.in_ready", {31'd0, in_ready}, 32'd0);
         tick();
         checkAll("stall_hold", 1'b1, 4'd1, 32'h1000, 32'h2000, 5'd10);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("release.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      checkAll("stallB", 1'b1, 4'd2, 32'h3000, 32'h4000, 5'd11);
      applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      checkOutput("stallB_once.valid", {31'd0, out_valid}, 32'd0);
      setForward(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      // Flush with an incoming item while C is held: both disappear.
      out_ready = 1'b0;
      applyStimulus(1'b1, 4'd6, 2'd0, 1'b0, 5'd1, 32'h50, 5'd2, 32'h51, 32'h0, 32'h0, 5'd12);
      tick();
      checkAll("flushC", 1'b1, 4'd6, 32'h50, 32'h51, 5'd12);
      flush = 1'b1;
      applyStimulus(1'b1, 4'd7, 2'd0, 1'b0, 5'd1, 32'h60, 5'd2, 32'h61, 32'h0, 32'h0, 5'd13);
      checkOutput("flush.in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      checkAll("flush_drop", 1'b0, 4'd6, 32'h50, 32'h51, 5'd12);
      flush = 1'b0;
      applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
      tick();
      checkOutput("post_flush.valid", {31'd0, out_valid}, 32'd0);

      // Reset during a stall discards the held entry and beats a capture.
      applyStimulus(1'b1, 4'd8, 2'd0, 1'b0, 5'd1, 32'h70, 5'd2, 32'h71, 32'h0, 32'h0, 5'd14);
      tick();
      checkAll("stallE", 1'b1, 4'd8, 32'h70, 32'h71, 5'd14);
      reset = 1'b1;
      applyStimulus(1'b1, 4'd9, 2'd0, 1'b0, 5'd1, 32'h80, 5'd2, 32'h81, 32'h0, 32'h0, 5'd15);
      tick();
      reset = 1'b0;
      applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0);
      checkAll("reset_stall", 1'b0, 4'd0, 32'h0, 32'h0, 5'd0);
      checkOutput("reset_stall.in_ready", {31'd0, in_ready}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
